l2_port_arbiter: RTL
====================

L2_PORT_ARBITER -- requirements
Module: l2_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, request/L2 address width.
REQ-002 Parameter LINE_W, 128, cache line data width.
REQ-003 Parameter TIMEOUT, 255, max cycles a granted L2 operation may run before abort (8-bit counter).
REQ-004 clk  in  1  clock; rising-edge active.
REQ-005 reset  in  1  reset: synchronous, active-high.
REQ-006 rd0, wr0  in  1 each  requester 0 (I-side L1 controller) line-fill / writeback request.
REQ-007 addr0  in  ADDR_W, wdata0  in  LINE_W  requester 0 address and writeback line.
REQ-008 rd1, wr1, addr1, wdata1  in  1/1/ADDR_W/LINE_W  same for requester 1 (D-side).
REQ-009 gnt0, gnt1  out  1 each  requester currently owns the L2 port.
REQ-010 ack0, ack1  out  1 each  fill data valid for that requester (one-cycle pulse).
REQ-011 done0, done1  out  1 each  writeback complete for that requester (one-cycle pulse).
REQ-012 l2_rd, l2_wr  out  1 each  command to L2; l2_addr  out  ADDR_W; l2_wdata  out  LINE_W.
REQ-013 l2_ack  in  1  L2 fill data valid; l2_done  in  1  L2 write complete.
REQ-014 busy  out  1  port owned; timeout_err  out  1  sticky abort flag.

Function
REQ-015 States IDLE, OWN0, OWN1; encoded in 2 bits; unused code returns to IDLE next cycle.
REQ-016 IDLE: any of rd0/wr0/rd1/wr1 high at cycle N -> winner's state entered, gntX, busy and l2_rd or l2_wr asserted from cycle N+1.
REQ-017 Both requesters pending in IDLE: grant the one not recorded in last_owner (round-robin); last_owner updated on every grant.
REQ-018 Requester asserting rdX and wrX together: wr served first (writeback precedes fill).
REQ-019 On grant, op (rd/wr), addr and wdata latched; l2_addr/l2_wdata/l2_rd/l2_wr driven from latches only; requester input changes during ownership ignored.
REQ-020 OWNx with op=rd: l2_ack high -> ackX=1 same cycle (combinational from l2_ack & ownership), state IDLE next cycle.
REQ-021 OWNx with op=wr: l2_done high -> doneX=1 same cycle, state IDLE next cycle.
REQ-022 l2_ack/l2_done not matching latched op, or arriving in IDLE, ignored: no ack/done pulse, no state change.
REQ-023 Minimum one IDLE cycle between consecutive grants; no back-to-back ownership.
REQ-024 Timeout counter cleared on grant, incremented each OWN cycle without completion; reaching TIMEOUT -> abort to IDLE, no ack/done, timeout_err set and held until reset.
REQ-025 Completion on same cycle counter reaches TIMEOUT: completion wins, no abort.
REQ-026 ackX/doneX never asserted for the non-owning requester; gnt0 and gnt1 never both high.
REQ-027 All outputs except ackX/doneX registered.

Reset
REQ-028 reset high at any edge: state IDLE, gnt0/gnt1/busy/l2_rd/l2_wr/timeout_err = 0, l2_addr/l2_wdata = 0, counter 0, last_owner = 1 (requester 0 wins first tie).
REQ-029 Reset mid-operation drops in-flight transaction; later l2_ack/l2_done ignored in IDLE.

Verification
REQ-030 rd0=1 addr0=0x0000_1A40 at cycle 1 -> gnt0=1, l2_rd=1, l2_addr=0x0000_1A40 at cycle 2; l2_ack at cycle 5 -> ack0=1 cycle 5, gnt0=0 cycle 6.
REQ-031 rd0 and rd1 together after reset -> requester 0 granted; both re-requesting after completion -> requester 1 granted next.
REQ-032 rd1=wr1=1, wdata1=0xDEADBEEF... -> l2_wr first with that data; l2_done -> done1 pulse, then rd1 served after one IDLE cycle.
REQ-033 TIMEOUT=4, grant, no l2_ack -> abort after 4 OWN cycles, timeout_err=1 until reset, no ack pulse; l2_ack on 4th cycle instead -> ack, no error.
REQ-034 Reset asserted during OWN1 -> all outputs 0 next cycle; l2_ack following reset produces no ack1.
REQ-035 l2_done while owner op=rd -> no done/ack, stays OWN until l2_ack.

Source files
------------

// File: rtl/l2_port_arbiter.sv
//-----------------------------------------------------------------------------
// l2_port_arbiter
//
// Shares the single L2 port between two L1 controllers: requester 0 (I-side)
// and requester 1 (D-side). While the port is idle, one pending requester is
// granted ownership. Its operation (fill or writeback), address and
// writeback line are captured at grant time. The L2 command is then driven
// from those captured values until L2 reports completion or the operation
// times out.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   rdX, wrX             requester X line-fill / writeback request
//   addrX, wdataX        requester X address and writeback line
//   gntX                 requester X owns the L2 port          (registered)
//   ackX                 fill data valid for requester X       (combinational)
//   doneX                writeback complete for requester X    (combinational)
//   l2_rd, l2_wr         command to L2                         (registered)
//   l2_addr, l2_wdata    captured address / line to L2         (registered)
//   l2_ack, l2_done      L2 fill data valid / write complete
//   busy                 port currently owned                  (registered)
//   timeout_err          sticky: an operation was aborted      (registered)
//-----------------------------------------------------------------------------
module l2_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [LINE_W-1:0] wdata0,
  input  logic              rd1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [LINE_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic              done0,
  output logic              done1,
  output logic              l2_rd,
  output logic              l2_wr,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic              l2_ack,
  input  logic              l2_done,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  // The abort limit is compared against an 8-bit cycle counter.
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t              state_q, state_d;
  logic                last_owner_q, last_owner_d;
  logic                op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                timeout_err_q, timeout_err_d;
  logic                gnt0_q, gnt0_d;
  logic                gnt1_q, gnt1_d;
  logic                busy_q, busy_d;
  logic                l2_rd_q, l2_rd_d;
  logic                l2_wr_q, l2_wr_d;

  logic                pend0;
  logic                pend1;
  logic                complete;
  logic [7:0]          cnt_inc;

  // Next-state, capture and registered-output computation.
  always_comb begin
    state_d       = state_q;
    last_owner_d  = last_owner_q;
    op_wr_d       = op_wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;

    pend0    = rd0 | wr0;
    pend1    = rd1 | wr1;
    // Only the completion that matches the captured operation counts.
    complete = op_wr_q ? l2_done : l2_ack;
    cnt_inc  = cnt_q + 8'd1;

    case (state_q)
      IDLE: begin
        // On a tie, the requester that did not own the port last time wins.
        // Writeback is chosen over fill when both are raised together.
        if (pend0 && (!pend1 || last_owner_q)) begin
          state_d      = OWN0;
          last_owner_d = 1'b0;
          op_wr_d      = wr0;
          addr_d       = addr0;
          wdata_d      = wdata0;
          cnt_d        = 8'd0;
        end else if (pend1) begin
          state_d      = OWN1;
          last_owner_d = 1'b1;
          op_wr_d      = wr1;
          addr_d       = addr1;
          wdata_d      = wdata1;
          cnt_d        = 8'd0;
        end else begin
          state_d      = IDLE;
        end
      end
      OWN0, OWN1: begin
        // Completion is tested first so that it wins over an abort
        // falling on the same cycle.
        if (complete) begin
          state_d = IDLE;
        end else if (cnt_inc == TO_LIMIT) begin
          state_d       = IDLE;
          cnt_d         = cnt_inc;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    gnt0_d  = (state_d == OWN0);
    gnt1_d  = (state_d == OWN1);
    busy_d  = (state_d == OWN0) || (state_d == OWN1);
    l2_rd_d = busy_d && !op_wr_d;
    l2_wr_d = busy_d && op_wr_d;
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_owner_q  <= 1'b1;
      op_wr_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= 8'd0;
      timeout_err_q <= 1'b0;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      busy_q        <= 1'b0;
      l2_rd_q       <= 1'b0;
      l2_wr_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_owner_q  <= last_owner_d;
      op_wr_q       <= op_wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
      gnt0_q        <= gnt0_d;
      gnt1_q        <= gnt1_d;
      busy_q        <= busy_d;
      l2_rd_q       <= l2_rd_d;
      l2_wr_q       <= l2_wr_d;
    end
  end

  // Completion pulses are qualified by current ownership, so a stray
  // l2_ack/l2_done while idle or for the other operation is dropped.
  assign ack0  = (state_q == OWN0) && !op_wr_q && l2_ack;
  assign ack1  = (state_q == OWN1) && !op_wr_q && l2_ack;
  assign done0 = (state_q == OWN0) &&  op_wr_q && l2_done;
  assign done1 = (state_q == OWN1) &&  op_wr_q && l2_done;

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign busy        = busy_q;
  assign l2_rd       = l2_rd_q;
  assign l2_wr       = l2_wr_q;
  assign l2_addr     = addr_q;
  assign l2_wdata    = wdata_q;
  assign timeout_err = timeout_err_q;

endmodule
